cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL provide parameters, one per line:
  AINDEX_WIDTH  6   set-index width; 64 sets
  CHANNEL_WIDTH 3   way-select width; 8 ways
  TAG_WIDTH     10  tag width
  DATA_WIDTH    64  word width
REQ-002 SHALL provide ports, one per line:
  clk            in   1        clock, rising edge
  reset          in   1        synchronous, active-high
  req_valid      in   1        CPU request valid
  req_ready      out  1        controller accepts request
  req_we         in   1        1 = write, 0 = read
  req_addr       in   TAG+AIDX word address {tag, index}
  req_wdata      in   DATA     write data
  rsp_valid      out  1        one-cycle completion pulse
  rsp_rdata      out  DATA     read data, valid with rsp_valid
  mem_req_valid  out  1        backing-memory request
  mem_req_ready  in   1        backing memory accepts
  mem_req_we     out  1        backing write
  mem_req_addr   out  TAG+AIDX backing address
  mem_req_wdata  out  DATA     backing write data
  mem_rsp_valid  in   1        backing read data valid
  mem_rsp_rdata  in   DATA     backing read data
  dm_addr        out  AIDX     data-array set index
  dm_chan        out  CHW      data-array way
  dm_wr          out  1        data-array write strobe
  dm_wdata       out  DATA     data-array write data
  dm_q           in   DATA     data-array combinational read data
REQ-003 Clock clk; reset is synchronous, active-high.

Function
REQ-004 SHALL implement states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WRITE_THRU, RESP.
REQ-005 IDLE: req_ready=1. On req_valid, SHALL latch we/addr/wdata and go to LOOKUP. req_ready=0 in all other states.
REQ-006 LOOKUP: SHALL compare the latched tag against all 8 valid tags of the set in one cycle. dm_addr=index, dm_chan=hit way.
REQ-007 Read hit: SHALL register dm_q into rsp_rdata, then go to RESP. Read-hit latency is req accept to rsp_valid = 2 cycles.
REQ-008 Read miss: SHALL go to MISS_REQ. mem_req_valid=1, we=0, addr=latched address; hold until mem_req_ready, then go to MISS_WAIT.
REQ-009 MISS_WAIT: on mem_rsp_valid, SHALL in the same cycle:
  - assert dm_wr with dm_chan=victim and dm_wdata=mem_rsp_rdata;
  - set that way's tag and valid bit;
  - load rsp_rdata;
  - go to RESP.
REQ-010 Victim selection: the lowest-index invalid way is chosen first. If no way is invalid, the per-set 3-bit round-robin pointer is used and increments mod 8, wrapping 7->0, only on a fill that used it.
REQ-011 Writes are write-through, no-write-allocate.
  - Write hit: SHALL assert dm_wr in LOOKUP at the hit way with req_wdata.
  - Hit or miss: SHALL then go to WRITE_THRU. mem_req_valid=1, we=1, hold until mem_req_ready, then go to RESP.
  - Write miss: tags unchanged.
REQ-012 RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata holds its value until the next load.
REQ-013 dm_wr SHALL be 0 except in the cycles given in REQ-009 and REQ-011. mem_req_* fields SHALL be stable while mem_req_valid=1 and ready=0.
REQ-014 mem_rsp_valid outside MISS_WAIT SHALL be ignored.

Reset
REQ-015 On reset, SHALL set:
  - state=IDLE;
  - all valid bits=0 and all round-robin pointers=0;
  - rsp_valid, mem_req_valid, dm_wr, req_ready=0;
  - rsp_rdata=0.
REQ-016 Reset mid-operation SHALL abandon the transaction. A late mem_rsp_valid SHALL not write the array. req_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-017 Macro CACHE_CTRL_STATS_EN:
  - Defined: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0. Each increments once per LOOKUP by hit/miss and saturates at 0xFFFFFFFF.
  - Undefined: neither port nor counters exist.

Structure
REQ-018 Package cache_pkg SHALL hold:
  - width constants (AINDEX_WIDTH, CHANNEL_WIDTH, TAG_WIDTH, DATA_WIDTH);
  - the state enum typedef;
  - the {tag, index} address struct typedef.
REQ-019 Sub-module cache_tag_array SHALL hold the valid bits, tags and round-robin pointers. It outputs hit, hit_way and victim_way combinationally for a given index and tag, and accepts a synchronous fill update.

Verification
REQ-020 Scenario: after reset, read 0x0005 -> miss. mem_req addr=0x0005; reply 0xAAAA -> dm_wr at set 5 way 0; rsp_rdata=0xAAAA.
REQ-021 Scenario: repeat read 0x0005 -> no mem_req; rsp_valid 2 cycles after accept; rsp_rdata=0xAAAA.
REQ-022 Scenario: fill set 3 with tags 0..7, then read tag 8 set 3 -> victim way 0; next miss -> way 1; pointer wraps after way 7.
REQ-023 Scenario: write 0x0005 data 0x1234 on hit -> dm_wr way 0 plus mem write 0x1234. Write to an uncached address -> mem write only, no dm_wr.
REQ-024 Scenario: mem_req_ready held 0 for 5 cycles -> mem_req fields stable; rsp_valid only after accept.
REQ-025 Scenario: reset asserted in MISS_WAIT, then mem_rsp_valid -> no dm_wr. Re-read of the same address misses. With CACHE_CTRL_STATS_EN, counters read 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, controller state encoding and the {tag, index} word-address layout
// for the write-through set-associative cache controller.
package cache_pkg;

  localparam int AINDEX_WIDTH  = 6;
  localparam int CHANNEL_WIDTH = 3;
  localparam int TAG_WIDTH     = 10;
  localparam int DATA_WIDTH    = 64;
  localparam int ADDR_WIDTH    = TAG_WIDTH + AINDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    MISS_REQ   = 3'd2,
    MISS_WAIT  = 3'd3,
    WRITE_THRU = 3'd4,
    RESP       = 3'd5
  } state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [AINDEX_WIDTH-1:0] index;
  } addr_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// Bus bundle of the cache controller: CPU request/response, backing memory and data-array port.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; while valid
// is 1 and ready is 0 the sender keeps valid and all payload fields unchanged.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_rdata;

  logic [AINDEX_WIDTH-1:0]  dm_addr;
  logic [CHANNEL_WIDTH-1:0] dm_chan;
  logic                     dm_wr;
  logic [DATA_WIDTH-1:0]    dm_wdata;
  logic [DATA_WIDTH-1:0]    dm_q;

  state_e                  state_dbg;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, dm_q,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output dm_addr, dm_chan, dm_wr, dm_wdata, state_dbg
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, dm_q,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  dm_addr, dm_chan, dm_wr, dm_wdata, state_dbg
  );

endinterface

// File: rtl/cache_tag_array.sv
// Per-set valid bits, tags and round-robin victim pointers; combinational hit/victim lookup
// for one index and a synchronous fill of the chosen victim way.
module cache_tag_array #(
  parameter int AINDEX_WIDTH  = 6,
  parameter int CHANNEL_WIDTH = 3,
  parameter int TAG_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AINDEX_WIDTH-1:0]  index_i,
  input  logic [TAG_WIDTH-1:0]     tag_i,
  input  logic                     fill_i,
  output logic                     hit_o,
  output logic [CHANNEL_WIDTH-1:0] hit_way_o,
  output logic [CHANNEL_WIDTH-1:0] victim_way_o
);

  localparam int NUM_SETS = 1 << AINDEX_WIDTH;
  localparam int NUM_WAYS = 1 << CHANNEL_WIDTH;

  logic [NUM_WAYS-1:0]      valid_q [NUM_SETS];
  logic [TAG_WIDTH-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [CHANNEL_WIDTH-1:0] rr_q    [NUM_SETS];

  logic [NUM_WAYS-1:0]      set_valid;
  logic                     any_invalid;
  logic [CHANNEL_WIDTH-1:0] free_way;

  // Scanning downward leaves the lowest-index invalid way in free_way.
  always_comb begin
    set_valid   = valid_q[index_i];
    hit_o       = 1'b0;
    hit_way_o   = '0;
    any_invalid = 1'b0;
    free_way    = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        any_invalid = 1'b1;
        free_way    = CHANNEL_WIDTH'(w);
      end
      if (set_valid[w] && (tag_q[index_i][w] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = CHANNEL_WIDTH'(w);
      end
    end
    victim_way_o = any_invalid ? free_way : rr_q[index_i];
  end

  // The pointer only advances when it actually picked the victim.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (fill_i) begin
      valid_q[index_i][victim_way_o] <= 1'b1;
      if (!any_invalid) begin
        rr_q[index_i] <= rr_q[index_i] + CHANNEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[index_i][victim_way_o] <= tag_i;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate cache controller with read-miss fill from backing memory.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
  parameter int AINDEX_WIDTH  = cache_pkg::AINDEX_WIDTH,
  parameter int CHANNEL_WIDTH = cache_pkg::CHANNEL_WIDTH,
  parameter int TAG_WIDTH     = cache_pkg::TAG_WIDTH,
  parameter int DATA_WIDTH    = cache_pkg::DATA_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  cache_ctrl_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  import cache_pkg::*;

  state_e                   state_q;
  addr_t                    addr_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     rsp_valid_q;
  logic                     mem_req_valid_q;

  logic                     hit;
  logic [CHANNEL_WIDTH-1:0] hit_way;
  logic [CHANNEL_WIDTH-1:0] victim_way;
  logic                     mem_fill;

  // Gated by reset so a response landing while reset is held never touches the arrays.
  assign mem_fill = (state_q == MISS_WAIT) && bus.mem_rsp_valid && !reset;

  cache_tag_array #(
    .AINDEX_WIDTH (AINDEX_WIDTH),
    .CHANNEL_WIDTH(CHANNEL_WIDTH),
    .TAG_WIDTH    (TAG_WIDTH)
  ) u_tags (
    .clk         (clk),
    .reset       (reset),
    .index_i     (addr_q.index),
    .tag_i       (addr_q.tag),
    .fill_i      (mem_fill),
    .hit_o       (hit),
    .hit_way_o   (hit_way),
    .victim_way_o(victim_way)
  );

  assign bus.req_ready     = (state_q == IDLE) && !reset;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.dm_addr       = addr_q.index;
  assign bus.dm_chan       = (state_q == MISS_WAIT) ? victim_way : hit_way;
  assign bus.dm_wr         = mem_fill || ((state_q == LOOKUP) && we_q && hit && !reset);
  assign bus.dm_wdata      = (state_q == MISS_WAIT) ? bus.mem_rsp_rdata : wdata_q;
  assign bus.state_dbg     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      rsp_valid_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (we_q) begin
            mem_req_valid_q <= 1'b1;
            state_q         <= WRITE_THRU;
          end else if (hit) begin
            rdata_q     <= bus.dm_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            mem_req_valid_q <= 1'b1;
            state_q         <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.mem_rsp_valid) begin
            rdata_q     <= bus.mem_rsp_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WRITE_THRU: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b1;
            state_q         <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: bus-level CPU driver with a reactive backing memory
// and a behavioural data array; each scenario task checks its own expected values.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_ctrl_if bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Behavioural data array: combinational read, write on the clock edge.
  logic [DATA_WIDTH-1:0] dmem [64][8];
  assign bus.dm_q = dmem[bus.dm_addr][bus.dm_chan];
  always @(posedge clk) begin
    if (bus.dm_wr) dmem[bus.dm_addr][bus.dm_chan] <= bus.dm_wdata;
  end

  // Observations gathered by cpu_txn for the calling scenario.
  int                    o_dm_wr_cnt;
  logic [2:0]            o_dm_chan;
  logic [5:0]            o_dm_addr;
  logic [DATA_WIDTH-1:0] o_dm_wdata;
  int                    o_mem_cnt;
  logic                  o_mem_we;
  logic [15:0]           o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  bit                    o_mem_stable;
  int                    o_latency;
  logic [DATA_WIDTH-1:0] o_rdata;
  bit                    o_timeout;
  logic                  o_rsp_after;
  logic                  o_ready_after;

  // One CPU transaction; memory accepts after rdelay stalled cycles and answers reads next cycle.
  task automatic cpu_txn(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                         input logic [63:0] mdata, input int rdelay);
    int cyc;
    int wcnt;
    bit pend;
    bit seen;
    o_dm_wr_cnt = 0; o_dm_chan = '0; o_dm_addr = '0; o_dm_wdata = '0;
    o_mem_cnt = 0; o_mem_we = 1'b0; o_mem_addr = '0; o_mem_wdata = '0; o_mem_stable = 1'b1;
    o_latency = -1; o_rdata = '0; o_timeout = 1'b0; o_rsp_after = 1'b0; o_ready_after = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) begin
      o_timeout = 1'b1;
      bus.req_valid = 1'b0;
      return;
    end
    cyc = 0; wcnt = 0; pend = 1'b0; seen = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      bus.req_valid     = 1'b0;
      bus.mem_rsp_valid = pend;
      bus.mem_rsp_rdata = pend ? mdata : '0;
      pend              = 1'b0;
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        if (!seen) begin
          o_mem_we = bus.mem_req_we; o_mem_addr = bus.mem_req_addr; o_mem_wdata = bus.mem_req_wdata;
          seen = 1'b1;
        end else if (bus.mem_req_we !== o_mem_we || bus.mem_req_addr !== o_mem_addr ||
                     bus.mem_req_wdata !== o_mem_wdata) begin
          o_mem_stable = 1'b0;
        end
        if (wcnt >= rdelay) begin
          bus.mem_req_ready = 1'b1;
          o_mem_cnt++;
          pend = !bus.mem_req_we;
        end
        wcnt++;
      end
      #1;
      if (bus.dm_wr) begin
        o_dm_wr_cnt++; o_dm_chan = bus.dm_chan; o_dm_addr = bus.dm_addr; o_dm_wdata = bus.dm_wdata;
      end
      if (bus.rsp_valid) begin
        o_latency = cyc;
        o_rdata   = bus.rsp_rdata;
        break;
      end
      if (cyc >= 40) begin
        o_timeout = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    #1;
    o_rsp_after   = bus.rsp_valid;
    o_ready_after = bus.req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid got %0b want 0", bus.mem_req_valid); end
    checks++; if (bus.dm_wr !== 1'b0) begin errors++; $display("FAIL rst_dm_wr got %0b want 0", bus.dm_wr); end
    checks++; if (bus.rsp_rdata !== 64'h0) begin errors++; $display("FAIL rst_rsp_rdata got %0h want 0", bus.rsp_rdata); end
    checks++; if (bus.state_dbg !== IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", bus.state_dbg, IDLE); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b want 1", bus.req_ready); end
`ifdef CACHE_CTRL_STATS_EN
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rst_stats got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
  endtask

  task automatic test_read_miss();
    cpu_txn(1'b0, 16'h0005, 64'h0, 64'hAAAA, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL miss_timeout got 1 want 0"); end
    checks++; if (o_mem_cnt !== 1) begin errors++; $display("FAIL miss_mem_cnt got %0d want 1", o_mem_cnt); end
    checks++; if (o_mem_addr !== 16'h0005 || o_mem_we !== 1'b0) begin errors++; $display("FAIL miss_mem_req got addr %0h we %0b want 5/0", o_mem_addr, o_mem_we); end
    checks++; if (o_dm_wr_cnt !== 1) begin errors++; $display("FAIL miss_dm_wr_cnt got %0d want 1", o_dm_wr_cnt); end
    checks++; if (o_dm_addr !== 6'd5 || o_dm_chan !== 3'd0) begin errors++; $display("FAIL miss_fill_loc got set %0d way %0d want 5/0", o_dm_addr, o_dm_chan); end
    checks++; if (o_dm_wdata !== 64'hAAAA) begin errors++; $display("FAIL miss_fill_data got %0h want aaaa", o_dm_wdata); end
    checks++; if (o_rdata !== 64'hAAAA) begin errors++; $display("FAIL miss_rdata got %0h want aaaa", o_rdata); end
    checks++; if (o_latency !== 4) begin errors++; $display("FAIL miss_latency got %0d want 4", o_latency); end
    checks++; if (o_rsp_after !== 1'b0) begin errors++; $display("FAIL miss_rsp_one_cycle got %0b want 0", o_rsp_after); end
    checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL miss_ready_after got %0b want 1", o_ready_after); end
`ifdef CACHE_CTRL_STATS_EN
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd1) begin errors++; $display("FAIL miss_stats got %0d/%0d want 0/1", hit_count, miss_count); end
`endif
  endtask

  task automatic test_read_hit();
    cpu_txn(1'b0, 16'h0005, 64'h0, 64'hDEAD, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL hit_timeout got 1 want 0"); end
    checks++; if (o_mem_cnt !== 0) begin errors++; $display("FAIL hit_mem_cnt got %0d want 0", o_mem_cnt); end
    checks++; if (o_dm_wr_cnt !== 0) begin errors++; $display("FAIL hit_dm_wr_cnt got %0d want 0", o_dm_wr_cnt); end
    checks++; if (o_latency !== 2) begin errors++; $display("FAIL hit_latency got %0d want 2", o_latency); end
    checks++; if (o_rdata !== 64'hAAAA) begin errors++; $display("FAIL hit_rdata got %0h want aaaa", o_rdata); end
`ifdef CACHE_CTRL_STATS_EN
    checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL hit_stats got %0d/%0d want 1/1", hit_count, miss_count); end
`endif
  endtask

  task automatic test_victim();
    logic [15:0] a;
    int exp_w;
    for (int t = 0; t <= 16; t++) begin
      a = {10'(t), 6'd3};
      exp_w = (t < 8) ? t : (t - 8) % 8;
      cpu_txn(1'b0, a, 64'h0, 64'h3000 + 64'(t), 0);
      checks++; if (o_timeout || o_mem_cnt !== 1) begin errors++; $display("FAIL victim_miss t=%0d got mem_cnt %0d want 1", t, o_mem_cnt); end
      checks++; if (o_dm_wr_cnt !== 1 || o_dm_addr !== 6'd3 || int'(o_dm_chan) !== exp_w) begin
        errors++; $display("FAIL victim_way t=%0d got set %0d way %0d want 3/%0d", t, o_dm_addr, o_dm_chan, exp_w);
      end
    end
    cpu_txn(1'b0, {10'd9, 6'd3}, 64'h0, 64'hBAD, 0);
    checks++; if (o_mem_cnt !== 0 || o_rdata !== 64'h3009) begin errors++; $display("FAIL victim_rehit got mem_cnt %0d rdata %0h want 0/3009", o_mem_cnt, o_rdata); end
  endtask

  task automatic test_write();
    cpu_txn(1'b1, 16'h0005, 64'h1234, 64'h0, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL wr_hit_timeout got 1 want 0"); end
    checks++; if (o_dm_wr_cnt !== 1 || o_dm_chan !== 3'd0 || o_dm_wdata !== 64'h1234) begin
      errors++; $display("FAIL wr_hit_dm got cnt %0d way %0d data %0h want 1/0/1234", o_dm_wr_cnt, o_dm_chan, o_dm_wdata);
    end
    checks++; if (o_mem_cnt !== 1 || o_mem_we !== 1'b1 || o_mem_addr !== 16'h0005 || o_mem_wdata !== 64'h1234) begin
      errors++; $display("FAIL wr_hit_mem got cnt %0d we %0b addr %0h data %0h want 1/1/5/1234", o_mem_cnt, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    checks++; if (o_latency !== 3) begin errors++; $display("FAIL wr_hit_latency got %0d want 3", o_latency); end
    cpu_txn(1'b0, 16'h0005, 64'h0, 64'hDEAD, 0);
    checks++; if (o_mem_cnt !== 0 || o_rdata !== 64'h1234) begin errors++; $display("FAIL wr_hit_readback got mem_cnt %0d rdata %0h want 0/1234", o_mem_cnt, o_rdata); end
    cpu_txn(1'b1, 16'h0200, 64'h5555, 64'h0, 0);
    checks++; if (o_dm_wr_cnt !== 0) begin errors++; $display("FAIL wr_miss_dm_wr got %0d want 0", o_dm_wr_cnt); end
    checks++; if (o_mem_cnt !== 1 || o_mem_addr !== 16'h0200 || o_mem_wdata !== 64'h5555) begin
      errors++; $display("FAIL wr_miss_mem got cnt %0d addr %0h data %0h want 1/200/5555", o_mem_cnt, o_mem_addr, o_mem_wdata);
    end
    checks++; if (o_rdata !== 64'h1234) begin errors++; $display("FAIL wr_rdata_hold got %0h want 1234", o_rdata); end
    cpu_txn(1'b0, 16'h0200, 64'h0, 64'h6666, 0);
    checks++; if (o_mem_cnt !== 1 || o_rdata !== 64'h6666) begin errors++; $display("FAIL wr_no_alloc got mem_cnt %0d rdata %0h want 1/6666", o_mem_cnt, o_rdata); end
  endtask

  task automatic test_backpressure();
    cpu_txn(1'b1, 16'h0005, 64'h7777, 64'h0, 5);
    checks++; if (o_timeout || !o_mem_stable) begin errors++; $display("FAIL bp_wr_stable got stable %0b timeout %0b want 1/0", o_mem_stable, o_timeout); end
    checks++; if (o_latency !== 8 || o_mem_cnt !== 1) begin errors++; $display("FAIL bp_wr_latency got %0d cnt %0d want 8/1", o_latency, o_mem_cnt); end
    cpu_txn(1'b0, 16'h0085, 64'h0, 64'h8585, 5);
    checks++; if (o_timeout || !o_mem_stable) begin errors++; $display("FAIL bp_rd_stable got stable %0b timeout %0b want 1/0", o_mem_stable, o_timeout); end
    checks++; if (o_latency !== 9 || o_mem_addr !== 16'h0085) begin errors++; $display("FAIL bp_rd_req got latency %0d addr %0h want 9/85", o_latency, o_mem_addr); end
    checks++; if (o_dm_chan !== 3'd1 || o_rdata !== 64'h8585) begin errors++; $display("FAIL bp_rd_fill got way %0d rdata %0h want 1/8585", o_dm_chan, o_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0045; bus.req_wdata = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rmid_mem_req got %0b want 1", bus.mem_req_valid); end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    checks++; if (bus.state_dbg !== MISS_WAIT) begin errors++; $display("FAIL rmid_state got %0d want %0d", bus.state_dbg, MISS_WAIT); end
    reset = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'hBEEF;
    #1;
    checks++; if (bus.dm_wr !== 1'b0) begin errors++; $display("FAIL rmid_dm_wr_in_reset got %0b want 0", bus.dm_wr); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.dm_wr !== 1'b0) begin errors++; $display("FAIL rmid_dm_wr_late got %0b want 0", bus.dm_wr); end
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got ready %0b rsp %0b want 1/0", bus.req_ready, bus.rsp_valid); end
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.state_dbg !== IDLE) begin errors++; $display("FAIL rmid_ignored got rsp %0b state %0d want 0/0", bus.rsp_valid, bus.state_dbg); end
`ifdef CACHE_CTRL_STATS_EN
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rmid_stats got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
    cpu_txn(1'b0, 16'h0045, 64'h0, 64'h4545, 0);
    checks++; if (o_mem_cnt !== 1 || o_dm_chan !== 3'd0 || o_rdata !== 64'h4545) begin
      errors++; $display("FAIL rmid_reread got cnt %0d way %0d rdata %0h want 1/0/4545", o_mem_cnt, o_dm_chan, o_rdata);
    end
    cpu_txn(1'b0, 16'h0005, 64'h0, 64'h0505, 0);
    checks++; if (o_mem_cnt !== 1 || o_dm_chan !== 3'd1) begin errors++; $display("FAIL rmid_cleared got cnt %0d way %0d want 1/1", o_mem_cnt, o_dm_chan); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    reset = 1'b1;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_victim();
    test_write();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
